// File: rtl/relu_grad_arr.sv
// relu_grad_arr: ReLU backward-pass mask array.
// The forward pass stores one activity-mask row per input row in a DEPTH-row FIFO.
// The backward pass pops the masks in arrival order and applies them to the
// gradient rows.
// Optional build macro: RELU_GRAD_LEAKY_EN. When it is defined, inactive lanes
// pass grad >>> 3 instead of zero.
module relu_grad_arr #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ARR_INPUTS = 16,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             fwd_valid,
    input  logic [DATA_WIDTH*ARR_INPUTS-1:0] fwd_in,
    output logic                             fwd_ready,
    input  logic                             grad_valid,
    input  logic [DATA_WIDTH*ARR_INPUTS-1:0] grad_in,
    output logic                             grad_ready,
    output logic [DATA_WIDTH*ARR_INPUTS-1:0] grad_out,
    output logic                             grad_out_valid,
    output logic [$clog2(DEPTH):0]           count,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned ARR_WIDTH = DATA_WIDTH * ARR_INPUTS;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;

    logic [ARR_INPUTS-1:0] mask_mem_q [DEPTH];
    logic [ARR_INPUTS-1:0] mask_mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ARR_WIDTH-1:0]  grad_out_q, grad_out_d;
    logic                  grad_out_valid_q, grad_out_valid_d;

    logic [ARR_INPUTS-1:0] fwd_mask_c;
    logic [ARR_INPUTS-1:0] rd_mask_c;
    logic [ARR_WIDTH-1:0]  grad_masked_c;
    logic                  push_c;
    logic                  pop_c;

    // Ready flags come only from the registered count.
    assign full           = (count_q == CNT_W'(DEPTH));
    assign empty          = (count_q == '0);
    assign fwd_ready      = !full;
    assign grad_ready     = !empty;
    assign count          = count_q;
    assign grad_out       = grad_out_q;
    assign grad_out_valid = grad_out_valid_q;

    // A lane is active when it is strictly positive: the sign bit is clear and the value is non-zero.
    always_comb begin
        fwd_mask_c = '0;
        for (int unsigned i = 0; i < ARR_INPUTS; i++) begin
            fwd_mask_c[i] = !fwd_in[i*DATA_WIDTH + DATA_WIDTH - 1]
                            && (|fwd_in[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Apply the mask at the head of the FIFO to the incoming gradient row.
    always_comb begin
        rd_mask_c     = mask_mem_q[rd_ptr_q];
        grad_masked_c = '0;
        for (int unsigned i = 0; i < ARR_INPUTS; i++) begin
            if (rd_mask_c[i]) begin
                grad_masked_c[i*DATA_WIDTH +: DATA_WIDTH] = grad_in[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
`ifdef RELU_GRAD_LEAKY_EN
                grad_masked_c[i*DATA_WIDTH +: DATA_WIDTH] =
                    DATA_WIDTH'($signed(grad_in[i*DATA_WIDTH +: DATA_WIDTH]) >>> 3);
`else
                grad_masked_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
            end
        end
    end

    // FIFO pointer, count and output next-state logic. A clear overrides push and pop.
    always_comb begin
        push_c           = fwd_valid && fwd_ready && !clear;
        pop_c            = grad_valid && grad_ready && !clear;
        mask_mem_d       = mask_mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        grad_out_d       = grad_out_q;
        grad_out_valid_d = pop_c;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                mask_mem_d[wr_ptr_q] = fwd_mask_c;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                grad_out_d = grad_masked_c;
            end
            if (push_c && !pop_c) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers. An async reset discards all stored masks immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mask_mem_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            grad_out_q       <= '0;
            grad_out_valid_q <= 1'b0;
        end else begin
            mask_mem_q       <= mask_mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            grad_out_q       <= grad_out_d;
            grad_out_valid_q <= grad_out_valid_d;
        end
    end

endmodule

// File: tb/tb_relu_grad_arr.sv
// Directed bench for relu_grad_arr: table-driven mask vectors plus FIFO corner sequences.
module tb_relu_grad_arr;

    localparam int unsigned DW    = 16;
    localparam int unsigned N     = 16;
    localparam int unsigned AW    = DW * N;
    localparam int unsigned DEPTH = 8;

`ifdef RELU_GRAD_LEAKY_EN
    localparam logic [15:0] INACT_100 = 16'd12;
    localparam logic [15:0] INACT_M16 = 16'hFFFE;
    localparam logic [15:0] INACT_M1  = 16'hFFFF;
`else
    localparam logic [15:0] INACT_100 = 16'd0;
    localparam logic [15:0] INACT_M16 = 16'd0;
    localparam logic [15:0] INACT_M1  = 16'd0;
`endif

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          fwd_valid;
    logic [AW-1:0] fwd_in;
    logic          fwd_ready;
    logic          grad_valid;
    logic [AW-1:0] grad_in;
    logic          grad_ready;
    logic [AW-1:0] grad_out;
    logic          grad_out_valid;
    logic [3:0]    count;
    logic          full;
    logic          empty;

    relu_grad_arr #(.DATA_WIDTH(DW), .ARR_INPUTS(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fwd_valid(fwd_valid), .fwd_in(fwd_in), .fwd_ready(fwd_ready),
        .grad_valid(grad_valid), .grad_in(grad_in), .grad_ready(grad_ready),
        .grad_out(grad_out), .grad_out_valid(grad_out_valid),
        .count(count), .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   mask;
        logic [AW-1:0] fwd;
        logic [AW-1:0] grad;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t        tab [8];
    logic [15:0] mq [$];
    int          checks;
    int          failures;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Forward row whose positive lanes are exactly the set bits of pos; inactive lanes use 0 or negative values.
    function automatic logic [AW-1:0] mk_fwd(input logic [15:0] pos);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            case (i % 4)
                0: r[i*16 +: 16] = pos[i] ? 16'h0001 : 16'h0000;
                1: r[i*16 +: 16] = pos[i] ? 16'h7FFF : 16'hFFFF;
                2: r[i*16 +: 16] = pos[i] ? 16'h1234 : 16'h8000;
                default: r[i*16 +: 16] = pos[i] ? 16'h0005 : 16'hFFFD;
            endcase
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] mk_grad(input int seed);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(N); i++) begin
            r[i*16 +: 16] = 16'(seed * 911 + i * 2345 - 20000);
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_row(input logic [AW-1:0] g, input logic [15:0] m);
        logic [AW-1:0]      r;
        logic signed [15:0] l;
        for (int i = 0; i < int'(N); i++) begin
            l = g[i*16 +: 16];
`ifdef RELU_GRAD_LEAKY_EN
            r[i*16 +: 16] = m[i] ? l : (l >>> 3);
`else
            r[i*16 +: 16] = m[i] ? l : 16'h0000;
`endif
        end
        return r;
    endfunction

    initial begin
        logic [15:0]   masks [8];
        logic [AW-1:0] row;
        logic [AW-1:0] exp;
        logic [AW-1:0] last_exp;
        logic [15:0]   m;
        int            pidx;
        int            gidx;

        checks   = 0;
        failures = 0;
        masks[0] = 16'hA5A5; masks[1] = 16'hFFFF; masks[2] = 16'h0000; masks[3] = 16'h0001;
        masks[4] = 16'h8000; masks[5] = 16'h5A5A; masks[6] = 16'h1234; masks[7] = 16'hF00F;
        for (int i = 0; i < 8; i++) begin
            tab[i].mask = masks[i];
            tab[i].fwd  = mk_fwd(masks[i]);
            tab[i].grad = mk_grad(i + 1);
            tab[i].exp  = exp_row(tab[i].grad, masks[i]);
        end

        rst_n = 1'b0; clear = 1'b0; fwd_valid = 1'b0; grad_valid = 1'b0;
        fwd_in = '0; grad_in = '0;
        #23;
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_fwd_ready", AW'(fwd_ready), AW'(1));
        chk("rst_grad_ready", AW'(grad_ready), AW'(0));
        chk("rst_empty", AW'(empty), AW'(1));
        chk("rst_full", AW'(full), AW'(0));
        chk("rst_count", AW'(count), AW'(0));
        chk("rst_grad_out", grad_out, '0);
        chk("rst_grad_out_valid", AW'(grad_out_valid), AW'(0));

        // Single row: lanes {5, 0, -3, 0x7FFF, 0...}
        row = '0;
        row[0*16 +: 16] = 16'd5;
        row[2*16 +: 16] = 16'hFFFD;
        row[3*16 +: 16] = 16'h7FFF;
        fwd_in = row; fwd_valid = 1'b1;
        step();
        fwd_valid = 1'b0;
        chk("one_count", AW'(count), AW'(1));
        chk("one_grad_ready", AW'(grad_ready), AW'(1));
        for (int i = 0; i < int'(N); i++) grad_in[i*16 +: 16] = 16'd100;
        grad_valid = 1'b1;
        step();
        grad_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) exp[i*16 +: 16] = (i == 0 || i == 3) ? 16'd100 : INACT_100;
        chk("one_valid", AW'(grad_out_valid), AW'(1));
        chk("one_grad_out", grad_out, exp);
        step();
        chk("one_valid_drop", AW'(grad_out_valid), AW'(0));
        chk("one_grad_out_hold", grad_out, exp);
        chk("one_empty", AW'(empty), AW'(1));

        // Fill to full with fwd_valid held, then an ignored ninth push
        fwd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fwd_in = tab[i].fwd;
            step();
        end
        chk("fill_full", AW'(full), AW'(1));
        chk("fill_fwd_ready", AW'(fwd_ready), AW'(0));
        chk("fill_count", AW'(count), AW'(8));
        fwd_in = mk_fwd(16'hFFFF);
        step();
        fwd_valid = 1'b0;
        chk("ninth_count", AW'(count), AW'(8));

        // Drain in push order
        grad_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            grad_in = tab[i].grad;
            step();
            chk($sformatf("drain_valid_%0d", i), AW'(grad_out_valid), AW'(1));
            chk($sformatf("drain_out_%0d", i), grad_out, tab[i].exp);
        end
        grad_valid = 1'b0;
        chk("drain_empty", AW'(empty), AW'(1));
        chk("drain_grad_ready", AW'(grad_ready), AW'(0));

        // Steady state at count=3 with simultaneous push and pop; both pointers wrap
        fwd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fwd_in = tab[i].fwd;
            mq.push_back(tab[i].mask);
            step();
        end
        chk("ss_count_init", AW'(count), AW'(3));
        grad_valid = 1'b1;
        last_exp = '0;
        for (int k = 0; k < 20; k++) begin
            pidx = (3 + k) % 8;
            gidx = (k * 3) % 8;
            fwd_in  = tab[pidx].fwd;
            grad_in = tab[gidx].grad;
            step();
            m = mq.pop_front();
            mq.push_back(tab[pidx].mask);
            last_exp = exp_row(tab[gidx].grad, m);
            chk($sformatf("ss_out_%0d", k), grad_out, last_exp);
            chk($sformatf("ss_count_%0d", k), AW'(count), AW'(3));
        end
        grad_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fwd_in = tab[i].fwd;
            step();
        end
        fwd_valid = 1'b0;
        chk("pre_clear_count", AW'(count), AW'(5));

        // Clear wins over simultaneous push and pop
        clear = 1'b1; fwd_valid = 1'b1; grad_valid = 1'b1;
        fwd_in = tab[1].fwd; grad_in = tab[1].grad;
        step();
        clear = 1'b0; fwd_valid = 1'b0; grad_valid = 1'b0;
        chk("clear_count", AW'(count), AW'(0));
        chk("clear_empty", AW'(empty), AW'(1));
        chk("clear_grad_ready", AW'(grad_ready), AW'(0));
        chk("clear_valid", AW'(grad_out_valid), AW'(0));
        chk("clear_grad_out_kept", grad_out, last_exp);

        // Async reset between edges with count=4 and a fresh output row
        fwd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fwd_in = tab[i].fwd;
            step();
        end
        fwd_valid = 1'b0;
        grad_valid = 1'b1; grad_in = tab[0].grad;
        step();
        grad_valid = 1'b0;
        chk("prereset_count", AW'(count), AW'(4));
        chk("prereset_valid", AW'(grad_out_valid), AW'(1));
        chk("prereset_out", grad_out, tab[0].exp);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", AW'(count), AW'(0));
        chk("async_full", AW'(full), AW'(0));
        chk("async_empty", AW'(empty), AW'(1));
        chk("async_valid", AW'(grad_out_valid), AW'(0));
        chk("async_grad_out", grad_out, '0);
        #3;
        rst_n = 1'b1;
        step();

        // Inactive-lane gradient: zero by default, >>>3 in the leaky build
        row = '0;
        row[0*16 +: 16] = 16'hFFF9;
        row[1*16 +: 16] = 16'd9;
        fwd_in = row; fwd_valid = 1'b1;
        step();
        fwd_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) grad_in[i*16 +: 16] = 16'hFFF0;
        grad_in[2*16 +: 16] = 16'hFFFF;
        grad_valid = 1'b1;
        step();
        grad_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) exp[i*16 +: 16] = INACT_M16;
        exp[1*16 +: 16] = 16'hFFF0;
        exp[2*16 +: 16] = INACT_M1;
        chk("leaky_valid", AW'(grad_out_valid), AW'(1));
        chk("leaky_out", grad_out, exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
